// File: rtl/key_word_packer_pkg.sv
// Shared types and constants for the final-key word packer.
// The key word width is fixed here; the other dimensions are module parameters.
package key_word_packer_pkg;

    localparam int unsigned OUT_W          = 32;
    localparam int unsigned DEF_GAMMA      = 13;
    localparam int unsigned DEF_KEEP_W     = 5;
    localparam int unsigned DEF_N_ELEM     = 256;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    localparam int unsigned FILL_W          = $clog2(OUT_W);
    localparam int unsigned WORDS_PER_BLOCK = (DEF_N_ELEM * DEF_KEEP_W + OUT_W - 1) / OUT_W;

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] word;
    } key_word_t;

    typedef enum logic [0:0] {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

endpackage

// File: rtl/key_word_packer_if.sv
// Element input and key-word output bundle of the packer.
// slave is the packer side; master is the upstream/downstream side.
interface key_word_packer_if #(
    parameter int unsigned GAMMA   = key_word_packer_pkg::DEF_GAMMA,
    parameter int unsigned LEVEL_W = $clog2(key_word_packer_pkg::DEF_FIFO_DEPTH + 1)
);
    import key_word_packer_pkg::*;

    logic               valid_in;
    logic [GAMMA-1:0]   data_z_in;
    logic [OUT_W-1:0]   key_data;
    logic               key_valid;
    logic               key_ready;
    logic               key_last;
    logic [LEVEL_W-1:0] fifo_level;
    logic               overflow;
    logic               clear_overflow;
    logic               block_done;

    modport master (
        output valid_in, data_z_in, key_ready, clear_overflow,
        input  key_data, key_valid, key_last, fifo_level, overflow, block_done
    );

    modport slave (
        input  valid_in, data_z_in, key_ready, clear_overflow,
        output key_data, key_valid, key_last, fifo_level, overflow, block_done
    );

endinterface

// File: rtl/key_word_fifo.sv
// First-word-fall-through FIFO of {last, word} entries built as a shift register,
// so the head is always slot 0 and slots at or above the level stay zero.
module key_word_fifo
    import key_word_packer_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  key_word_t          wr_data,
    input  logic               rd_req,
    output key_word_t          head,
    output logic               head_valid,
    output logic [LEVEL_W-1:0] level,
    output logic               drop_c
);

    key_word_t          slot_q [DEPTH];
    key_word_t          slot_n [DEPTH];
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_n;
    logic [LEVEL_W-1:0] wr_pos;
    logic               valid_q;
    logic               do_rd;
    logic               do_wr;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        do_rd   = rd_req && (level_q != '0);
        do_wr   = wr_en && ((level_q != LEVEL_W'(DEPTH)) || do_rd);
        drop_c  = wr_en && !do_wr;
        wr_pos  = level_q - LEVEL_W'(do_rd);
        level_n = level_q + LEVEL_W'(do_wr) - LEVEL_W'(do_rd);

        for (int i = 0; i < DEPTH; i++) begin
            slot_n[i] = slot_q[i];
        end
        if (do_rd) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slot_n[i] = slot_q[i+1];
            end
            slot_n[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_wr && (wr_pos == LEVEL_W'(i))) begin
                slot_n[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_n[i];
            end
            level_q <= level_n;
            valid_q <= (level_n != '0);
        end
    end

    assign head       = slot_q[0];
    assign head_valid = valid_q;
    assign level      = level_q;

endmodule

// File: rtl/key_word_packer.sv
// Packs the KEEP_W low bits of each compressed element LSB-first into key words,
// marking the final word of every N_ELEM-element block and buffering words in a FIFO.
module key_word_packer
    import key_word_packer_pkg::*;
#(
    parameter int unsigned GAMMA      = DEF_GAMMA,
    parameter int unsigned KEEP_W     = DEF_KEEP_W,
    parameter int unsigned N_ELEM     = DEF_N_ELEM,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    key_word_packer_if.slave bus
);

    localparam int unsigned ACC_W   = OUT_W + KEEP_W;
    localparam int unsigned SUM_W   = $clog2(2 * OUT_W);
    localparam int unsigned CNT_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH + 1);

    pack_state_t        state_q;
    pack_state_t        state_n;
    logic [OUT_W-1:0]   acc_q;
    logic [OUT_W-1:0]   acc_n;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_n;
    logic [OUT_W-1:0]   pend_q;
    logic [OUT_W-1:0]   pend_n;
    logic               overflow_q;
    logic               block_done_q;

    logic [GAMMA-1:0]   data_z;
    logic [KEEP_W-1:0]  elem;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   wide;
    logic [OUT_W-1:0]   remainder;
    logic [CNT_W-1:0]   cnt_inc;
    logic               is_last;
    logic               word_done;

    logic               wr_en_c;
    key_word_t          wr_data_c;
    logic               done_c;
    logic               drop_c;
    key_word_t          head;
    logic               head_valid;
    logic [LEVEL_W-1:0] level;

    assign data_z = bus.data_z_in;
    assign elem   = data_z[KEEP_W-1:0];

    // Next-state and packing datapath; at most one FIFO write is issued per cycle.
    always_comb begin
        state_n   = state_q;
        acc_n     = acc_q;
        fill_n    = fill_q;
        cnt_n     = cnt_q;
        pend_n    = pend_q;
        wr_en_c   = 1'b0;
        wr_data_c = '0;
        done_c    = 1'b0;

        sum       = SUM_W'(fill_q) + SUM_W'(KEEP_W);
        wide      = ACC_W'(acc_q) | (ACC_W'(elem) << fill_q);
        remainder = OUT_W'(wide[ACC_W-1:OUT_W]);
        word_done = (sum >= SUM_W'(OUT_W));
        is_last   = (cnt_q == CNT_W'(N_ELEM - 1));
        cnt_inc   = is_last ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            PACK: begin
                if (bus.valid_in) begin
                    cnt_n = cnt_inc;
                    if (word_done) begin
                        wr_en_c        = 1'b1;
                        wr_data_c.word = wide[OUT_W-1:0];
                        acc_n          = remainder;
                        fill_n         = FILL_W'(sum - SUM_W'(OUT_W));
                    end else begin
                        acc_n  = wide[OUT_W-1:0];
                        fill_n = FILL_W'(sum);
                    end
                    // Block end: close the word now, or defer the spill-over to FLUSH.
                    if (is_last) begin
                        acc_n  = '0;
                        fill_n = '0;
                        if (!word_done || (sum == SUM_W'(OUT_W))) begin
                            wr_en_c        = 1'b1;
                            wr_data_c.word = wide[OUT_W-1:0];
                            wr_data_c.last = 1'b1;
                            done_c         = 1'b1;
                        end else begin
                            pend_n  = remainder;
                            state_n = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                wr_en_c        = 1'b1;
                wr_data_c.word = pend_q;
                wr_data_c.last = 1'b1;
                done_c         = 1'b1;
                state_n        = PACK;
                // Accumulator is already clear, so a new element 0 cannot complete a word.
                if (bus.valid_in) begin
                    acc_n  = wide[OUT_W-1:0];
                    fill_n = FILL_W'(sum);
                    cnt_n  = cnt_inc;
                end
            end
            default: state_n = PACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PACK;
            acc_q        <= '0;
            fill_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            overflow_q   <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            acc_q        <= acc_n;
            fill_q       <= fill_n;
            cnt_q        <= cnt_n;
            pend_q       <= pend_n;
            overflow_q   <= drop_c | (overflow_q & ~bus.clear_overflow);
            block_done_q <= done_c;
        end
    end

    key_word_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_c),
        .wr_data    (wr_data_c),
        .rd_req     (bus.key_ready),
        .head       (head),
        .head_valid (head_valid),
        .level      (level),
        .drop_c     (drop_c)
    );

    assign bus.key_data   = head.word;
    assign bus.key_last   = head.last;
    assign bus.key_valid  = head_valid;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
    assign bus.block_done = block_done_q;

endmodule

// File: tb/tb_key_word_packer.sv
// Directed bench for key_word_packer: default block geometry on dut_a,
// a 7-element block on dut_b to exercise the FLUSH path.
module tb_key_word_packer;
    import key_word_packer_pkg::*;

    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_w [40];
    logic [32:0] got [$];
    int          done_cnt;
    int          done_on_last;
    logic        hold = 1'b0;
    logic [32:0] hold_val;

    key_word_packer_if #(.GAMMA(13), .LEVEL_W(LW)) if_a ();
    key_word_packer_if #(.GAMMA(13), .LEVEL_W(LW)) if_b ();

    key_word_packer dut_a (.clk(clk), .rst(rst), .bus(if_a));
    key_word_packer #(.N_ELEM(7)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor for dut_a: collects transfers, block_done pulses, and hold stability.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 64'(if_a.key_valid), 64'd1);
                check("hold_word", 64'({if_a.key_last, if_a.key_data}), 64'(hold_val));
            end
            if (if_a.key_valid && if_a.key_ready) got.push_back({if_a.key_last, if_a.key_data});
            if (if_a.block_done) begin
                done_cnt++;
                if (if_a.key_valid && if_a.key_last) done_on_last++;
            end
            hold     = if_a.key_valid && !if_a.key_ready;
            hold_val = {if_a.key_last, if_a.key_data};
        end
    end

    // Bit-serial reference: element i contributes the 5 LSBs of i.
    task automatic build_model();
        logic [1279:0] bits;
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < 5; b++) bits[5*i+b] = i[b];
        for (int w = 0; w < 40; w++)
            for (int b = 0; b < 32; b++) exp_w[w][b] = bits[32*w+b];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [12:0] d);
        if_a.valid_in  = v;
        if_a.data_z_in = d;
        tick();
    endtask

    task automatic drive_b(input logic v, input logic [12:0] d);
        if_b.valid_in  = v;
        if_b.data_z_in = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic stream_a(input int gap, input logic [12:0] hi, input bit rnd_ready);
        for (int i = 0; i < 256; i++) begin
            if (rnd_ready) if_a.key_ready = 1'($urandom_range(0, 1));
            drive_a(1'b1, 13'(i) | hi);
            for (int g = 0; g < gap; g++) drive_a(1'b0, '0);
        end
        if_a.valid_in = 1'b0;
    endtask

    task automatic compare_block(input string tag);
        check({tag, "_count"}, 64'(got.size()), 64'd40);
        for (int w = 0; w < 40 && w < got.size(); w++) begin
            check($sformatf("%s_w%0d", tag, w), 64'(got[w][31:0]), 64'(exp_w[w]));
            check($sformatf("%s_last%0d", tag, w), 64'(got[w][32]), (w == 39) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic clear_capture();
        got.delete();
        done_cnt     = 0;
        done_on_last = 0;
    endtask

    initial begin
        if_a.valid_in = 1'b0; if_a.data_z_in = '0; if_a.key_ready = 1'b1; if_a.clear_overflow = 1'b0;
        if_b.valid_in = 1'b0; if_b.data_z_in = '0; if_b.key_ready = 1'b1; if_b.clear_overflow = 1'b0;
        build_model();
        rst = 1'b1;
        repeat (3) tick();

        check("rst_key_valid", 64'(if_a.key_valid), 64'd0);
        check("rst_key_last", 64'(if_a.key_last), 64'd0);
        check("rst_key_data", 64'(if_a.key_data), 64'd0);
        check("rst_fifo_level", 64'(if_a.fifo_level), 64'd0);
        check("rst_overflow", 64'(if_a.overflow), 64'd0);
        check("rst_block_done", 64'(if_a.block_done), 64'd0);
        rst = 1'b0;

        // Back-to-back block, e_i = i
        clear_capture();
        stream_a(0, 13'h0000, 1'b0);
        repeat (4) tick();
        compare_block("s1");
        if (got.size() >= 40) begin
            check("s1_word0_hand", 64'(got[0][31:0]), 64'h8A41_8820);
            check("s1_word1_hand", 64'(got[1][31:0]), 64'hC5A9_2839);
            check("s1_word39_hand", 64'(got[39][31:0]), 64'hFFBB_CDEB);
        end
        check("s1_done_cnt", 64'(done_cnt), 64'd1);
        check("s1_done_with_last", 64'(done_on_last), 64'd1);

        // Upper data bits set, then sparse valid_in
        clear_capture();
        stream_a(0, 13'h1FE0, 1'b0);
        repeat (4) tick();
        compare_block("s2a");
        check("s2a_done_cnt", 64'(done_cnt), 64'd1);
        clear_capture();
        stream_a(2, 13'h0000, 1'b0);
        repeat (4) tick();
        compare_block("s2b");
        check("s2b_done_cnt", 64'(done_cnt), 64'd1);

        // Backpressure: fill to 8, ninth word dropped
        clear_capture();
        if_a.key_ready = 1'b0;
        for (int i = 0; i <= 51; i++) drive_a(1'b1, 13'(i));
        check("s3_level_full", 64'(if_a.fifo_level), 64'd8);
        check("s3_no_overflow_yet", 64'(if_a.overflow), 64'd0);
        check("s3_head_word0", 64'({if_a.key_valid, if_a.key_data}), {31'd0, 1'b1, exp_w[0]});
        for (int i = 52; i <= 57; i++) drive_a(1'b1, 13'(i));
        if_a.valid_in = 1'b0;
        check("s3_overflow_set", 64'(if_a.overflow), 64'd1);
        check("s3_level_sat", 64'(if_a.fifo_level), 64'd8);
        if_a.key_ready = 1'b1;
        repeat (12) tick();
        check("s3_drain_count", 64'(got.size()), 64'd8);
        for (int w = 0; w < 8 && w < got.size(); w++)
            check($sformatf("s3_drain_w%0d", w), 64'(got[w]), 64'({1'b0, exp_w[w]}));
        check("s3_level_empty", 64'(if_a.fifo_level), 64'd0);
        check("s3_overflow_sticky", 64'(if_a.overflow), 64'd1);
        if_a.clear_overflow = 1'b1;
        tick();
        if_a.clear_overflow = 1'b0;
        check("s3_overflow_cleared", 64'(if_a.overflow), 64'd0);

        // Reset mid-block with three words buffered
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            if (i == 81) if_a.key_ready = 1'b0;
            drive_a(1'b1, 13'(i));
        end
        if_a.valid_in = 1'b0;
        check("s5_level_before", 64'(if_a.fifo_level), 64'd3);
        do_reset();
        check("s5_level_after", 64'(if_a.fifo_level), 64'd0);
        check("s5_valid_after", 64'(if_a.key_valid), 64'd0);
        check("s5_overflow_after", 64'(if_a.overflow), 64'd0);
        check("s5_data_after", 64'(if_a.key_data), 64'd0);
        if_a.key_ready = 1'b1;
        clear_capture();
        stream_a(0, 13'h0000, 1'b0);
        repeat (4) tick();
        compare_block("s5");

        // Random backpressure
        clear_capture();
        stream_a(0, 13'h0000, 1'b1);
        for (int n = 0; n < 400 && got.size() < 40; n++) begin
            if_a.key_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if_a.key_ready = 1'b1;
        repeat (4) tick();
        compare_block("s6");
        check("s6_done_cnt", 64'(done_cnt), 64'd1);

        // 7-element blocks: spill-over word via FLUSH, next block starts during FLUSH
        do_reset();
        for (int i = 0; i < 7; i++) drive_b(1'b1, 13'(i + 1));
        check("s4_b0w0", 64'({if_b.key_valid, if_b.key_last, if_b.key_data}), {30'd0, 2'b10, 32'hCC52_0C41});
        check("s4_b0w0_done", 64'(if_b.block_done), 64'd0);
        drive_b(1'b1, 13'd1);
        check("s4_b0w1", 64'({if_b.key_valid, if_b.key_last, if_b.key_data}), {30'd0, 2'b11, 32'h0000_0001});
        check("s4_b0w1_done", 64'(if_b.block_done), 64'd1);
        for (int i = 1; i < 7; i++) drive_b(1'b1, 13'(i + 1));
        check("s4_b1w0", 64'({if_b.key_valid, if_b.key_last, if_b.key_data}), {30'd0, 2'b10, 32'hCC52_0C41});
        drive_b(1'b0, '0);
        check("s4_b1w1", 64'({if_b.key_valid, if_b.key_last, if_b.key_data}), {30'd0, 2'b11, 32'h0000_0001});
        check("s4_b1w1_done", 64'(if_b.block_done), 64'd1);
        drive_b(1'b0, '0);
        check("s4_empty", 64'(if_b.key_valid), 64'd0);
        check("s4_no_overflow", 64'(if_b.overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
